// File: rtl/pc_sequencer_pkg.sv
// Shared constants and types for the PC sequencer and its branch comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds funct3 condition codes, default reset/trap vectors, the sequencer
// state encoding and a small alignment helper.
package pc_sequencer_pkg;

    // Architectural word width (PC, operands, branch target).
    localparam int unsigned WORD_W = 32;

    // Default vectors.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0010;

    // RISC-V branch funct3 codes. 3'b010 / 3'b011 are unused and never take.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Sequencer states.
    //   RUN     : fetching sequentially, may accept a branch
    //   RESOLVE : branch PC held while the target adder result arrives
    //   HOLD    : RESOLVE was stalled; decision waits on the captured target
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_HOLD    = 2'b10
    } seq_state_e;

    // Instruction targets must be word aligned; any low bit set traps.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between execute/fetch and the PC sequencer.
// Latency: n/a (wiring only).
// Backpressure: stall_i is a level hold request from downstream, no credits.
//
// Ports (slave = sequencer side):
//   stall_i, branch_valid_i, jump_i, br_funct3_i, rs1_i, rs2_i, addrBranch_i : into sequencer
//   pc_o, fetch_valid_o, flush_o, misaligned_o                               : out of sequencer
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
);

    logic              stall_i;
    logic              branch_valid_i;
    logic              jump_i;
    logic [2:0]        br_funct3_i;
    logic [DATA_W-1:0] rs1_i;
    logic [DATA_W-1:0] rs2_i;
    logic [DATA_W-1:0] addrBranch_i;
    logic [DATA_W-1:0] pc_o;
    logic              fetch_valid_o;
    logic              flush_o;
    logic              misaligned_o;

    // Execute / fetch side.
    modport master (
        output stall_i, branch_valid_i, jump_i, br_funct3_i,
               rs1_i, rs2_i, addrBranch_i,
        input  pc_o, fetch_valid_o, flush_o, misaligned_o
    );

    // PC sequencer side.
    modport slave (
        input  stall_i, branch_valid_i, jump_i, br_funct3_i,
               rs1_i, rs2_i, addrBranch_i,
        output pc_o, fetch_valid_o, flush_o, misaligned_o
    );

endinterface

// File: rtl/pc_sequencer_branch_cmp.sv
// Branch condition evaluator: funct3 + two operands -> taken condition.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
//
// Ports:
//   funct3_i : RISC-V branch funct3
//   rs1_i    : operand A
//   rs2_i    : operand B
//   cond_o   : 1 when the condition holds (0 for the unused codes)
module branch_cmp
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output logic              cond_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    always_comb begin
        cond_o = 1'b0;
        unique case (funct3_i)
            F3_BEQ:  cond_o = eq;
            F3_BNE:  cond_o = ~eq;
            F3_BLT:  cond_o = lt_s;
            F3_BGE:  cond_o = ~lt_s;
            F3_BLTU: cond_o = lt_u;
            F3_BGEU: cond_o = ~lt_u;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner and branch resolution: PC+4 fall-through or redirect.
// Latency: branch PC held 2 cycles, new PC on cycle 3; outputs registered.
// Backpressure: stall_i freezes PC in RUN and parks a pending decision in HOLD.
//
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : pc_sequencer_if.slave (branch inputs in, pc/fetch_valid/flush/misaligned out)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       DATA_W   = WORD_W,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF),
    parameter logic [DATA_W-1:0] TRAP_VEC = DATA_W'(TRAP_VEC_DEF)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pc_sequencer_if.slave   bus
);

    seq_state_e        state_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] target_q;
    logic              taken_q;
    logic              fetch_valid_q;
    logic              flush_q;
    logic              misaligned_q;

    logic              cond;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] decide_target;
    logic [DATA_W-1:0] resolve_pc_d;
    logic              resolve_flush_d;
    logic              resolve_mis_d;

    branch_cmp #(
        .DATA_W (DATA_W)
    ) u_branch_cmp (
        .funct3_i (bus.br_funct3_i),
        .rs1_i    (bus.rs1_i),
        .rs2_i    (bus.rs2_i),
        .cond_o   (cond)
    );

    // Wraps modulo 2^DATA_W by construction.
    assign pc_plus4 = pc_q + DATA_W'(4);

    // In RESOLVE the adder output is live this cycle; once parked in HOLD the
    // adder input may have moved on, so only the captured copy is trusted.
    assign decide_target = (state_q == ST_HOLD) ? target_q : bus.addrBranch_i;

    // Outcome of a resolved branch, used from both RESOLVE and HOLD.
    always_comb begin
        resolve_pc_d    = pc_plus4;
        resolve_flush_d = 1'b0;
        resolve_mis_d   = 1'b0;
        if (taken_q) begin
            resolve_flush_d = 1'b1;
            if (is_misaligned(decide_target[1:0])) begin
                resolve_pc_d  = TRAP_VEC;
                resolve_mis_d = 1'b1;
            end else begin
                resolve_pc_d  = decide_target;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            target_q      <= '0;
            taken_q       <= 1'b0;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            // Pulses default low; set only on the redirect cycle below.
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;

            unique case (state_q)
                ST_RUN: begin
                    if (bus.stall_i) begin
                        // Stall beats a same-cycle branch; it is re-presented later.
                        pc_q <= pc_q;
                    end else if (bus.branch_valid_i) begin
                        // PC held so the target adder sees the branch PC.
                        taken_q       <= bus.jump_i | cond;
                        state_q       <= ST_RESOLVE;
                        fetch_valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_plus4;
                    end
                end

                ST_RESOLVE: begin
                    target_q <= bus.addrBranch_i;
                    if (bus.stall_i) begin
                        state_q <= ST_HOLD;
                    end else begin
                        pc_q          <= resolve_pc_d;
                        flush_q       <= resolve_flush_d;
                        misaligned_q  <= resolve_mis_d;
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (!bus.stall_i) begin
                        pc_q          <= resolve_pc_d;
                        flush_q       <= resolve_flush_d;
                        misaligned_q  <= resolve_mis_d;
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.flush_o       = flush_q;
    assign bus.misaligned_o  = misaligned_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter owner and branch resolution stage. It drives PC to the fetch path and to the branch-target adder. It consumes the registered branch target, which arrives one cycle after PC and offset are presented. It evaluates the branch condition, then redirects PC and flushes fetch, or falls through to PC+4.

Parameters:
DATA_W, 32, PC, operand and target width (matches `WORD).
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TRAP_VEC, 32'h0000_0010, PC loaded when a taken target is misaligned.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
stall_i  in  1  hold request from downstream
branch_valid_i  in  1  conditional branch or jump in execute this cycle
jump_i  in  1  unconditional; qualifies branch_valid_i, forces taken
br_funct3_i  in  3  condition code (RISC-V funct3)
rs1_i  in  DATA_W  compare operand A
rs2_i  in  DATA_W  compare operand B
addrBranch_i  in  DATA_W  registered target from the target adder, valid in the cycle after branch_valid_i
pc_o  out  DATA_W  current PC; also feeds the target adder PC input
fetch_valid_o  out  1  fetched instruction at pc_o is usable
flush_o  out  1  one-cycle pulse: discard younger instructions
misaligned_o  out  1  one-cycle pulse: taken target had [1:0]!=0

Behaviour:
- Reset (rst_i=1 at edge): pc_o=RESET_PC, state=RUN, fetch_valid_o=1, flush_o=0, misaligned_o=0, taken_q=0, target_q=0. Reset overrides every other input in any state; any in-flight branch is discarded.
- Outputs are registered. flush_o and misaligned_o default to 0 every cycle unless set below.
- State RUN, fetch_valid_o=1:
  - If stall_i=1, hold PC.
  - Else if branch_valid_i=1, hold PC so the target adder samples the branch PC. Register taken_q=jump_i|cond. Go to RESOLVE.
  - Else pc_o<=pc_o+4.
- State RESOLVE, fetch_valid_o=0:
  - Always capture target_q<=addrBranch_i.
  - If stall_i=1, go to HOLD.
  - Else apply the decision (see below) and go to RUN.
- State HOLD, fetch_valid_o=0:
  - Wait while stall_i=1. Use target_q only; addrBranch_i is ignored because it may change.
  - When stall_i=0, apply the decision and go to RUN.
- Apply decision:
  - Taken with target[1:0]==0: pc_o<=target, flush_o=1 in the cycle pc_o=target.
  - Taken with target[1:0]!=0: pc_o<=TRAP_VEC, misaligned_o=1 and flush_o=1 in that cycle.
  - Not taken: pc_o<=pc_o+4, no flush.
- Branch latency: the branch PC is visible 2 cycles (RUN issue cycle plus RESOLVE); the next PC appears in cycle 3 without stall.
- cond by br_funct3_i:
  - 000 BEQ: equal.
  - 001 BNE: not equal.
  - 100 BLT: signed less-than.
  - 101 BGE: signed greater-or-equal.
  - 110 BLTU: unsigned less-than.
  - 111 BGEU: unsigned greater-or-equal.
  - 010/011: not taken (cond=0).
- Evaluation is combinational on rs1_i/rs2_i in the RUN issue cycle only.
- branch_valid_i in RESOLVE/HOLD is ignored.
- Arithmetic: PC+4 is modulo 2^DATA_W; 32'hFFFF_FFFC+4 gives 0. No overflow flag.
- Simultaneous stall_i and branch_valid_i in RUN: the stall wins; the branch is not accepted until stall_i=0.

Decomposition:
- Shared constants header (lagartoII_const.vh): funct3 codes BEQ..BGEU, RESET_PC/TRAP_VEC defaults, 2-bit state encodings RUN=00, RESOLVE=01, HOLD=10.
- One combinational sub-module, branch_cmp (funct3, rs1, rs2 -> cond), reusable by a later compare-forwarding stage.

Test Plan:
- Reset: hold rst_i 2 cycles, then release. Required: pc_o=0x0, fetch_valid_o=1, flush_o=0. Four idle cycles then give pc_o 0x4, 0x8, 0xC, 0x10.
- BEQ taken at pc_o=0x100, rs1=rs2=5, addrBranch_i=0x140 in RESOLVE. Required: pc_o=0x100 for 2 cycles (fetch_valid_o 1 then 0), then 0x140 with flush_o=1 for exactly one cycle.
- Signed vs unsigned with rs1=0xFFFF_FFFF, rs2=1:
  - BLT at 0x200, target 0x180: goes to 0x180.
  - BLTU at 0x200: not taken, goes to 0x204, flush_o stays 0.
- Misaligned: JAL-style (jump_i=1) at 0x300, addrBranch_i=0x342. Required: pc_o=0x10, misaligned_o=1 and flush_o=1 for one cycle.
- Stall in RESOLVE: addrBranch_i=0x140 on entry, stall_i=1 for 3 cycles while addrBranch_i changes to 0xDEAD_BEEC. Required: state HOLD, pc_o frozen; after release pc_o=0x140.
- Reset and wrap:
  - rst_i asserted in HOLD: next pc_o=0x0, state RUN, no flush_o.
  - Separately, pc_o=0xFFFF_FFFC with no branch: next pc_o=0x0.
